game_screen_fsm: RTL and testbench
==================================

GAME_SCREEN_FSM -- requirements
Module: game_screen_fsm

Interface
REQ-001 Parameter BLANK_CYC, default 25_000_000, length of the black transition screen in clk cycles (1 s at 25 MHz).
REQ-002 Parameter LIVES_INIT, default 3, lives loaded on each new game.
REQ-003 clk  input  1  system/pixel clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 key_pulse  input  5  one-cycle key code; 5'h1d = select.
REQ-006 menu_sel  input  2  menu screen choice: 00 = start stage 1; 11 = none; 01/10 are ignored.
REQ-007 die_boggle1  input  2  die screen choice: 00 = restart; 01 = menu; 11 = none; 10 is ignored.
REQ-008 stage1_die  input  1  one-cycle pulse from gameplay when the player is hit.
REQ-009 stage1_clear  input  1  one-cycle pulse from gameplay when the stage is cleared.
REQ-010 rgb_menu, rgb_stage1, rgb_die1, rgb_clear  input  3 each  screen pixel colours.
REQ-011 rgb  output  3  selected pixel colour to the VGA driver.
REQ-012 screen  output  3  current state code.
REQ-013 lives  output  2  remaining lives.
REQ-014 stage_rst  output  1  high while in BLANK; resets the gameplay logic.
REQ-015 die_scr_rst  output  1  one-cycle pulse on entry to DIE1; resets the die-screen selection box.

Function
REQ-016 States and codes SHALL be: MENU = 0, PLAY1 = 1, BLANK = 2, DIE1 = 3, CLEAR = 4; codes 5-7 return to MENU on the next clk.
REQ-017 MENU: menu_sel == 00 → lives = LIVES_INIT, go to BLANK.
REQ-018 PLAY1, stage1_clear → CLEAR; stage1_clear takes priority over a simultaneous stage1_die.
REQ-019 PLAY1, stage1_die with lives > 1 → lives decrements by 1, go to BLANK.
REQ-020 PLAY1, stage1_die with lives == 1 → lives = 0, go to DIE1.
REQ-021 PLAY1, stage1_die with lives == 0 (illegal) → treated as the lives == 1 case; lives never wraps.
REQ-022 BLANK: a cycle counter clears on entry and increments each clk; at count == BLANK_CYC-1 → PLAY1, so BLANK lasts exactly BLANK_CYC cycles.
REQ-023 DIE1, die_boggle1 == 00 → lives = LIVES_INIT, go to BLANK.
REQ-024 DIE1, die_boggle1 == 01 → MENU; die_boggle1 is sampled only in DIE1.
REQ-025 CLEAR, key_pulse == 5'h1d → MENU.
REQ-026 Inputs not named for the current state are ignored, including stage1_die and stage1_clear outside PLAY1.
REQ-027 rgb SHALL be combinational from the registered state, zero latency: MENU→rgb_menu, PLAY1→rgb_stage1, BLANK→3'b000, DIE1→rgb_die1, CLEAR→rgb_clear.
REQ-028 die_scr_rst SHALL be high for exactly the first clk cycle in DIE1.
REQ-029 A new transition SHALL be accepted no earlier than the cycle after entering a state; an event in the entry cycle is acted on.

Reset
REQ-030 rst asserted → state = MENU, lives = LIVES_INIT, counter = 0, die_scr_rst = 0; stage_rst = 0; rgb = rgb_menu.
REQ-031 rst mid-BLANK SHALL abort the transition immediately, with no PLAY1 entry after release.

Structure
REQ-032 State codes, the select key code 5'h1d and the selection codes 00/01/11 SHALL live in the shared package game_pkg, shared with the menu and die screens.
REQ-033 The BLANK counter SHALL be a sub-module blank_timer (start, done) of width $clog2(BLANK_CYC).
REQ-034 Everything else is a single FSM block plus the rgb mux.

Verification (BLANK_CYC = 4)
REQ-035 Reset, then menu_sel = 00 for 1 cycle → BLANK for 4 cycles with stage_rst = 1 → PLAY1; lives = 3.
REQ-036 Three stage1_die pulses, each after returning to PLAY1 → lives 3→2→1→0; third pulse → DIE1 with one die_scr_rst pulse; rgb == rgb_die1.
REQ-037 In DIE1, die_boggle1 = 00 → BLANK, then PLAY1, lives = 3.
REQ-038 In DIE1, die_boggle1 = 01 → MENU; rgb == rgb_menu.
REQ-039 stage1_die and stage1_clear in the same cycle with lives = 1 → CLEAR, lives stays 1; key_pulse = 5'h1d → MENU.
REQ-040 rst asserted at BLANK cycle 2 → MENU immediately; after release, no PLAY1 without a new menu_sel.

Source files
------------

// File: rtl/game_pkg.sv
// Shared screen codes and selection encodings used by the game screen FSM,
// the menu screen and the die screen.
package game_pkg;

    typedef enum logic [2:0] {
        ScrMenu  = 3'd0,
        ScrPlay1 = 3'd1,
        ScrBlank = 3'd2,
        ScrDie1  = 3'd3,
        ScrClear = 3'd4
    } screen_e;

    localparam logic [4:0] KeySelect = 5'h1d;

    // Selection box codes from the menu and die screens
    localparam logic [1:0] SelGo   = 2'b00;
    localparam logic [1:0] SelMenu = 2'b01;
    localparam logic [1:0] SelNone = 2'b11;

endpackage

// File: rtl/blank_timer.sv
// Cycle counter for the black transition screen; done marks the last cycle
// of a BLANK_CYC-long interval started by start.
module blank_timer #(
    parameter int unsigned BLANK_CYC = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic done
);

    localparam int unsigned CntW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLANK_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (run && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = run && (cnt_q == CntLast);

endmodule

// File: rtl/game_screen_fsm.sv
// Top-level screen sequencer: menu, stage 1 play, black transition, die and
// clear screens, plus the pixel colour mux for the selected screen.
module game_screen_fsm
    import game_pkg::*;
#(
    parameter int unsigned BLANK_CYC  = 25_000_000,
    parameter int unsigned LIVES_INIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_pulse,
    input  logic [1:0] menu_sel,
    input  logic [1:0] die_boggle1,
    input  logic       stage1_die,
    input  logic       stage1_clear,
    input  logic [2:0] rgb_menu,
    input  logic [2:0] rgb_stage1,
    input  logic [2:0] rgb_die1,
    input  logic [2:0] rgb_clear,
    output logic [2:0] rgb,
    output logic [2:0] screen,
    output logic [1:0] lives,
    output logic       stage_rst,
    output logic       die_scr_rst
);

    localparam logic [1:0] LivesInit = 2'(LIVES_INIT);

    screen_e    state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic       die_scr_rst_q, die_scr_rst_d;
    logic       blank_start, blank_done;

    blank_timer #(
        .BLANK_CYC(BLANK_CYC)
    ) u_blank_timer (
        .clk  (clk),
        .rst  (rst),
        .start(blank_start),
        .run  (state_q == ScrBlank),
        .done (blank_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ScrMenu;
            lives_q       <= LivesInit;
            die_scr_rst_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            die_scr_rst_q <= die_scr_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ScrMenu: begin
                if (menu_sel == SelGo) begin
                    lives_d = LivesInit;
                    state_d = ScrBlank;
                end
            end
            ScrPlay1: begin
                if (stage1_clear) begin
                    state_d = ScrClear;
                end else if (stage1_die) begin
                    // lives == 0 is illegal here; treat it like the last life
                    if (lives_q > 2'd1) begin
                        lives_d = lives_q - 2'd1;
                        state_d = ScrBlank;
                    end else begin
                        lives_d = 2'd0;
                        state_d = ScrDie1;
                    end
                end
            end
            ScrBlank: begin
                if (blank_done) begin
                    state_d = ScrPlay1;
                end
            end
            ScrDie1: begin
                if (die_boggle1 == SelGo) begin
                    lives_d = LivesInit;
                    state_d = ScrBlank;
                end else if (die_boggle1 == SelMenu) begin
                    state_d = ScrMenu;
                end
            end
            ScrClear: begin
                if (key_pulse == KeySelect) begin
                    state_d = ScrMenu;
                end
            end
            default: state_d = ScrMenu;
        endcase
    end

    assign blank_start   = (state_d == ScrBlank) && (state_q != ScrBlank);
    assign die_scr_rst_d = (state_d == ScrDie1) && (state_q != ScrDie1);

    always_comb begin
        rgb = 3'b000;
        case (state_q)
            ScrMenu:  rgb = rgb_menu;
            ScrPlay1: rgb = rgb_stage1;
            ScrBlank: rgb = 3'b000;
            ScrDie1:  rgb = rgb_die1;
            ScrClear: rgb = rgb_clear;
            default:  rgb = rgb_menu;
        endcase
        screen      = state_q;
        lives       = lives_q;
        stage_rst   = (state_q == ScrBlank);
        die_scr_rst = die_scr_rst_q;
    end

endmodule

// File: tb/tb_game_screen_fsm.sv
// Directed self-checking bench for game_screen_fsm with a 4-cycle blank screen.
module tb_game_screen_fsm;

    localparam logic [2:0] CMenu  = 3'd0;
    localparam logic [2:0] CPlay  = 3'd1;
    localparam logic [2:0] CBlank = 3'd2;
    localparam logic [2:0] CDie   = 3'd3;
    localparam logic [2:0] CClear = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] key_pulse;
    logic [1:0] menu_sel;
    logic [1:0] die_boggle1;
    logic       stage1_die;
    logic       stage1_clear;
    logic [2:0] rgb_menu   = 3'b001;
    logic [2:0] rgb_stage1 = 3'b010;
    logic [2:0] rgb_die1   = 3'b011;
    logic [2:0] rgb_clear  = 3'b100;
    logic [2:0] rgb;
    logic [2:0] screen;
    logic [1:0] lives;
    logic       stage_rst;
    logic       die_scr_rst;

    int tests_run    = 0;
    int tests_failed = 0;

    game_screen_fsm #(
        .BLANK_CYC (4),
        .LIVES_INIT(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_pulse   (key_pulse),
        .menu_sel    (menu_sel),
        .die_boggle1 (die_boggle1),
        .stage1_die  (stage1_die),
        .stage1_clear(stage1_clear),
        .rgb_menu    (rgb_menu),
        .rgb_stage1  (rgb_stage1),
        .rgb_die1    (rgb_die1),
        .rgb_clear   (rgb_clear),
        .rgb         (rgb),
        .screen      (screen),
        .lives       (lives),
        .stage_rst   (stage_rst),
        .die_scr_rst (die_scr_rst)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        key_pulse    = 5'h00;
        menu_sel     = 2'b11;
        die_boggle1  = 2'b11;
        stage1_die   = 1'b0;
        stage1_clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL reset_screen got %0d want %0d", screen, CMenu); end
        tests_run++; if (lives !== 2'd3) begin tests_failed++; $display("FAIL reset_lives got %0d want 3", lives); end
        tests_run++; if (stage_rst !== 1'b0) begin tests_failed++; $display("FAIL reset_stage_rst got %b want 0", stage_rst); end
        tests_run++; if (die_scr_rst !== 1'b0) begin tests_failed++; $display("FAIL reset_die_scr_rst got %b want 0", die_scr_rst); end
        tests_run++; if (rgb !== rgb_menu) begin tests_failed++; $display("FAIL reset_rgb got %b want %b", rgb, rgb_menu); end
        rst = 1'b0;
        tick();
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL idle_menu got %0d want %0d", screen, CMenu); end
    endtask

    task automatic test_start();
        menu_sel = 2'b01;
        tick();
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL menu_sel01_ignored got %0d want %0d", screen, CMenu); end
        menu_sel = 2'b00;
        tick();
        menu_sel = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            tests_run++; if (screen !== CBlank) begin tests_failed++; $display("FAIL start_blank_c%0d got %0d want %0d", i, screen, CBlank); end
            tests_run++; if (stage_rst !== 1'b1) begin tests_failed++; $display("FAIL start_stage_rst_c%0d got %b want 1", i, stage_rst); end
            tests_run++; if (rgb !== 3'b000) begin tests_failed++; $display("FAIL start_rgb_black_c%0d got %b want 000", i, rgb); end
            tick();
        end
        tests_run++; if (screen !== CPlay) begin tests_failed++; $display("FAIL start_play got %0d want %0d", screen, CPlay); end
        tests_run++; if (lives !== 2'd3) begin tests_failed++; $display("FAIL start_lives got %0d want 3", lives); end
        tests_run++; if (rgb !== rgb_stage1) begin tests_failed++; $display("FAIL start_rgb got %b want %b", rgb, rgb_stage1); end
        tests_run++; if (stage_rst !== 1'b0) begin tests_failed++; $display("FAIL start_stage_rst_low got %b want 0", stage_rst); end
    endtask

    // Expects to be entered in PLAY1 with 3 lives; die pulses land in the entry cycle
    task automatic test_die_sequence();
        logic [1:0] exp_lives;
        for (int k = 1; k <= 2; k++) begin
            stage1_die = 1'b1;
            tick();
            stage1_die = 1'b0;
            exp_lives = 2'(3 - k);
            tests_run++; if (screen !== CBlank) begin tests_failed++; $display("FAIL die%0d_blank got %0d want %0d", k, screen, CBlank); end
            tests_run++; if (lives !== exp_lives) begin tests_failed++; $display("FAIL die%0d_lives got %0d want %0d", k, lives, exp_lives); end
            repeat (4) tick();
            tests_run++; if (screen !== CPlay) begin tests_failed++; $display("FAIL die%0d_replay got %0d want %0d", k, screen, CPlay); end
        end
        stage1_die = 1'b1;
        tick();
        stage1_die = 1'b0;
        tests_run++; if (screen !== CDie) begin tests_failed++; $display("FAIL die3_screen got %0d want %0d", screen, CDie); end
        tests_run++; if (lives !== 2'd0) begin tests_failed++; $display("FAIL die3_lives got %0d want 0", lives); end
        tests_run++; if (die_scr_rst !== 1'b1) begin tests_failed++; $display("FAIL die3_scr_rst_first got %b want 1", die_scr_rst); end
        tests_run++; if (rgb !== rgb_die1) begin tests_failed++; $display("FAIL die3_rgb got %b want %b", rgb, rgb_die1); end
        // Inputs not belonging to DIE1 must be ignored
        stage1_die   = 1'b1;
        menu_sel     = 2'b00;
        die_boggle1  = 2'b10;
        tick();
        idle_inputs();
        tests_run++; if (die_scr_rst !== 1'b0) begin tests_failed++; $display("FAIL die3_scr_rst_second got %b want 0", die_scr_rst); end
        tests_run++; if (screen !== CDie) begin tests_failed++; $display("FAIL die3_ignore got %0d want %0d", screen, CDie); end
        tests_run++; if (lives !== 2'd0) begin tests_failed++; $display("FAIL die3_ignore_lives got %0d want 0", lives); end
    endtask

    task automatic test_restart();
        die_boggle1 = 2'b00;
        tick();
        die_boggle1 = 2'b11;
        tests_run++; if (screen !== CBlank) begin tests_failed++; $display("FAIL restart_blank got %0d want %0d", screen, CBlank); end
        tests_run++; if (lives !== 2'd3) begin tests_failed++; $display("FAIL restart_lives got %0d want 3", lives); end
        repeat (3) tick();
        tests_run++; if (screen !== CBlank) begin tests_failed++; $display("FAIL restart_blank_c4 got %0d want %0d", screen, CBlank); end
        tick();
        tests_run++; if (screen !== CPlay) begin tests_failed++; $display("FAIL restart_play got %0d want %0d", screen, CPlay); end
        tests_run++; if (lives !== 2'd3) begin tests_failed++; $display("FAIL restart_play_lives got %0d want 3", lives); end
    endtask

    task automatic test_die_to_menu();
        for (int k = 0; k < 3; k++) begin
            stage1_die = 1'b1;
            tick();
            stage1_die = 1'b0;
            if (k < 2) repeat (4) tick();
        end
        tests_run++; if (screen !== CDie) begin tests_failed++; $display("FAIL menu_path_die got %0d want %0d", screen, CDie); end
        die_boggle1 = 2'b01;
        tick();
        die_boggle1 = 2'b11;
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL die_to_menu got %0d want %0d", screen, CMenu); end
        tests_run++; if (rgb !== rgb_menu) begin tests_failed++; $display("FAIL die_to_menu_rgb got %b want %b", rgb, rgb_menu); end
        die_boggle1 = 2'b00;
        tick();
        die_boggle1 = 2'b11;
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL boggle_outside_die got %0d want %0d", screen, CMenu); end
    endtask

    task automatic test_clear_priority();
        menu_sel = 2'b00;
        tick();
        menu_sel = 2'b11;
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            stage1_die = 1'b1;
            tick();
            stage1_die = 1'b0;
            repeat (4) tick();
        end
        tests_run++; if (lives !== 2'd1) begin tests_failed++; $display("FAIL clear_pre_lives got %0d want 1", lives); end
        tests_run++; if (screen !== CPlay) begin tests_failed++; $display("FAIL clear_pre_play got %0d want %0d", screen, CPlay); end
        stage1_die   = 1'b1;
        stage1_clear = 1'b1;
        tick();
        stage1_die   = 1'b0;
        stage1_clear = 1'b0;
        tests_run++; if (screen !== CClear) begin tests_failed++; $display("FAIL clear_priority got %0d want %0d", screen, CClear); end
        tests_run++; if (lives !== 2'd1) begin tests_failed++; $display("FAIL clear_lives got %0d want 1", lives); end
        tests_run++; if (rgb !== rgb_clear) begin tests_failed++; $display("FAIL clear_rgb got %b want %b", rgb, rgb_clear); end
        key_pulse  = 5'h1c;
        stage1_die = 1'b1;
        tick();
        idle_inputs();
        tests_run++; if (screen !== CClear) begin tests_failed++; $display("FAIL clear_wrong_key got %0d want %0d", screen, CClear); end
        key_pulse = 5'h1d;
        tick();
        key_pulse = 5'h00;
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL clear_select got %0d want %0d", screen, CMenu); end
    endtask

    task automatic test_rst_mid_blank();
        menu_sel = 2'b00;
        tick();
        menu_sel = 2'b11;
        tick();
        tests_run++; if (screen !== CBlank) begin tests_failed++; $display("FAIL rstblank_pre got %0d want %0d", screen, CBlank); end
        #2;
        rst = 1'b1;
        #1;
        tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL rstblank_async got %0d want %0d", screen, CMenu); end
        tests_run++; if (stage_rst !== 1'b0) begin tests_failed++; $display("FAIL rstblank_stage_rst got %b want 0", stage_rst); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++; if (screen !== CMenu) begin tests_failed++; $display("FAIL rstblank_stay_c%0d got %0d want %0d", i, screen, CMenu); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_die_sequence();
        test_restart();
        test_die_to_menu();
        test_clear_priority();
        test_rst_mid_blank();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
